// File: rtl/change_dispenser_if.sv
// Bus between the main payment FSM (master) and the change dispenser (slave).
interface change_dispenser_if;
  logic [2:0] mainState;
  logic [4:0] inputMoney;
  logic [4:0] valueToPay;
  logic       noMoneyLeft;
  logic       coinValid;
  logic [4:0] coinOut;
  logic [4:0] remaining;
  logic [2:0] coinCount;
  logic [1:0] changeState;

  modport master (
    output mainState, inputMoney, valueToPay,
    input  noMoneyLeft, coinValid, coinOut, remaining, coinCount, changeState
  );

  modport slave (
    input  mainState, inputMoney, valueToPay,
    output noMoneyLeft, coinValid, coinOut, remaining, coinCount, changeState
  );
endinterface

// File: rtl/change_dispenser.sv
// Change / refund dispenser: loads the amount owed when the main FSM enters
// valid (3) or invalid (2) payment, pays it out largest coin first, then
// raises noMoneyLeft until the main FSM leaves {2,3}.
// Optional feature macro: COIN_GAP_EN (one idle cycle between coin strobes).
module change_dispenser (
  input  logic                clock,
  input  logic                reset,
  change_dispenser_if.slave   bus
);

  localparam int unsigned AMT_W  = 5;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DIFF_W = AMT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

`ifdef COIN_GAP_EN
  localparam state_e AFTER_COIN = ST_GAP;
`else
  localparam state_e AFTER_COIN = ST_DISPENSE;
`endif

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AMT_W-1:0]   coin_q, coin_d;
  logic               valid_q, valid_d;
  logic               nml_q, nml_d;

  logic               pay_active;
  logic [DIFF_W-1:0]  diff;
  logic [AMT_W-1:0]   change_amt;
  logic [AMT_W-1:0]   coin_sel;

  // Largest denomination not exceeding the amount still owed.
  function automatic logic [AMT_W-1:0] pick_coin(input logic [AMT_W-1:0] amt);
    if (amt >= AMT_W'(20))      return AMT_W'(20);
    else if (amt >= AMT_W'(10)) return AMT_W'(10);
    else if (amt >= AMT_W'(5))  return AMT_W'(5);
    else if (amt >= AMT_W'(2))  return AMT_W'(2);
    else                        return AMT_W'(1);
  endfunction

  // Change amount with a refund fallback if the price exceeds the money inserted.
  always_comb begin
    pay_active = (bus.mainState == 3'd2) || (bus.mainState == 3'd3);
    diff       = DIFF_W'(bus.inputMoney) - DIFF_W'(bus.valueToPay);
    change_amt = diff[DIFF_W-1] ? bus.inputMoney : diff[AMT_W-1:0];
    coin_sel   = pick_coin(rem_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    coin_d  = '0;
    valid_d = 1'b0;
    nml_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mainState == 3'd3) begin
          rem_d   = change_amt;
          cnt_d   = '0;
          state_d = ST_DISPENSE;
        end else if (bus.mainState == 3'd2) begin
          rem_d   = bus.inputMoney;
          cnt_d   = '0;
          state_d = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (!pay_active) begin
          rem_d   = '0;
          state_d = ST_IDLE;
        end else if (rem_q == '0) begin
          nml_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          coin_d  = coin_sel;
          valid_d = 1'b1;
          rem_d   = rem_q - coin_sel;
          cnt_d   = cnt_q + CNT_W'(1);
          if (rem_q == coin_sel) begin
            nml_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = AFTER_COIN;
          end
        end
      end
      ST_GAP: begin
        if (!pay_active) begin
          rem_d   = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DISPENSE;
        end
      end
      ST_DONE: begin
        if (!pay_active) state_d = ST_IDLE;
        else             nml_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      coin_q  <= '0;
      valid_q <= 1'b0;
      nml_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      coin_q  <= coin_d;
      valid_q <= valid_d;
      nml_q   <= nml_d;
    end
  end

  assign bus.noMoneyLeft = nml_q;
  assign bus.coinValid   = valid_q;
  assign bus.coinOut     = coin_q;
  assign bus.remaining   = rem_q;
  assign bus.coinCount   = cnt_q;
  assign bus.changeState = state_q;

endmodule
